// File: rtl/chip1127_pkg.sv
// Shared constants and types for the 1127A0 digital top: default timing parameters,
// synchronizer slot map and the GPIO status bit layout.
package chip1127_pkg;

  localparam int DEF_PERIOD_W  = 6;
  localparam int DEF_DMAX      = 56;
  localparam int DEF_DEAD      = 2;
  localparam int DEF_DEB_LEN   = 16;
  localparam int DEF_OCP_LIMIT = 4;

  // GPIO bit positions (GPIO1 is bit 0)
  localparam int NUM_GPIO      = 5;
  localparam int GPIO_ORIENT   = 0;
  localparam int GPIO_ATTACHED = 1;
  localparam int GPIO_FAULT    = 2;
  localparam int GPIO_PWM_EN   = 3;
  localparam int GPIO_WRAP     = 4;

  // Slots of the read-pad synchronizer vector
  localparam int NUM_SYNC   = 10;
  localparam int SY_CSP     = 0;
  localparam int SY_CSN     = 1;
  localparam int SY_VFB     = 2;
  localparam int SY_COMP    = 3;
  localparam int SY_BST     = 4;
  localparam int SY_VDRV    = 5;
  localparam int SY_CC1     = 6;
  localparam int SY_CC2     = 7;
  localparam int SY_TST     = 8;
  localparam int SY_GPIO_TS = 9;

  // Field order matches GPIO5..GPIO1 when packed
  typedef struct packed {
    logic wrap;
    logic pwm_en;
    logic fault;
    logic attached;
    logic orient;
  } status_t;

  function automatic int width_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/chip1127_if.sv
// Control/status bundle between the pad-side top (master) and the PWM core (slave).
interface chip1127_if;

  logic pwm_en;
  logic comp_s;
  logic csp_s;
  logic csn_s;
  logic bst_s;
  logic vdrv_s;
  logic vfb_s;
  logic hg;
  logic lg;
  logic wrap;
  logic fault;

  modport master (
    output pwm_en, comp_s, csp_s, csn_s, bst_s, vdrv_s, vfb_s,
    input  hg, lg, wrap, fault
  );

  modport slave (
    input  pwm_en, comp_s, csp_s, csn_s, bst_s, vdrv_s, vfb_s,
    output hg, lg, wrap, fault
  );

endinterface

// File: rtl/chip1127_pwm_core.sv
// Fixed-frequency synchronous-buck PWM: period counter, COMP-stepped duty,
// cycle-by-cycle and latched over-current protection, registered HG/LG gates.
module pwm_core
  import chip1127_pkg::*;
#(
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int DMAX      = DEF_DMAX,
  parameter int DEAD      = DEF_DEAD,
  parameter int OCP_LIMIT = DEF_OCP_LIMIT
) (
  input logic       clk,
  input logic       rst,
  chip1127_if.slave pif
);

  localparam int OCW = width_min1(OCP_LIMIT + 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] DMAX_V  = PERIOD_W'(DMAX);
  localparam logic [PERIOD_W-1:0] LG_END  = PERIOD_W'((1 << PERIOD_W) - 1 - DEAD);
  localparam logic [PERIOD_W:0]   DEAD_V  = (PERIOD_W + 1)'(DEAD);
  localparam logic [OCW-1:0]      OCP_LIM = OCW'(OCP_LIMIT);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic [OCW-1:0]      ocp_cnt_q, ocp_cnt_d;
  logic                ocp_cyc_q, ocp_cyc_d;
  logic                fault_q, fault_d;
  logic                hg_q, hg_d;
  logic                lg_q, lg_d;
  logic                wrap;
  logic                ocp_now;
  logic [PERIOD_W:0]   lg_start;

  assign wrap     = (cnt_q == CNT_MAX);
  assign ocp_now  = pif.csp_s & ~pif.csn_s;
  assign lg_start = {1'b0, duty_q} + DEAD_V;

  always_comb begin
    cnt_d     = cnt_q;
    duty_d    = duty_q;
    ocp_cyc_d = ocp_cyc_q;
    ocp_cnt_d = ocp_cnt_q;
    fault_d   = fault_q;

    if (!pif.pwm_en) begin
      cnt_d     = '0;
      duty_d    = '0;
      ocp_cyc_d = 1'b0;
      ocp_cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (wrap) begin
        if (pif.comp_s) begin
          if (duty_q < DMAX_V) duty_d = duty_q + 1'b1;
        end else if (duty_q != '0) begin
          duty_d = duty_q - 1'b1;
        end
        // An OCP sample on the wrap cycle counts for the closing period and carries over
        if (ocp_cyc_q || ocp_now) begin
          if (ocp_cnt_q != OCP_LIM) ocp_cnt_d = ocp_cnt_q + 1'b1;
        end else begin
          ocp_cnt_d = '0;
        end
        ocp_cyc_d = ocp_now;
      end else begin
        ocp_cyc_d = ocp_cyc_q | ocp_now;
      end
    end

    if (ocp_cnt_d == OCP_LIM) fault_d = 1'b1;

    hg_d = pif.pwm_en && (cnt_q < duty_q) && !ocp_cyc_d &&
           pif.bst_s && pif.vdrv_s && !pif.vfb_s;
    lg_d = pif.pwm_en && ({1'b0, cnt_q} >= lg_start) && (cnt_q <= LG_END) &&
           pif.vdrv_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      duty_q    <= '0;
      ocp_cnt_q <= '0;
      ocp_cyc_q <= 1'b0;
      fault_q   <= 1'b0;
      hg_q      <= 1'b0;
      lg_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      ocp_cnt_q <= ocp_cnt_d;
      ocp_cyc_q <= ocp_cyc_d;
      fault_q   <= fault_d;
      hg_q      <= hg_d;
      lg_q      <= lg_d;
    end
  end

  assign pif.hg    = hg_q;
  assign pif.lg    = lg_q;
  assign pif.wrap  = wrap;
  assign pif.fault = fault_q;

endmodule

// File: rtl/chip_top_1127a0.sv
// 1127A0 digital top: pad synchronizers, Type-C CC attach debounce, VBUS GATE,
// GPIO status/test-counter mux and pad tri-state handling around the PWM core.
module chip_top_1127a0
  import chip1127_pkg::*;
#(
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int DMAX      = DEF_DMAX,
  parameter int DEAD      = DEF_DEAD,
  parameter int DEB_LEN   = DEF_DEB_LEN,
  parameter int OCP_LIMIT = DEF_OCP_LIMIT
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  CSP,
  inout  wire  CSN,
  inout  wire  VFB,
  inout  wire  COMP,
  inout  wire  BST,
  inout  wire  VDRV,
  inout  wire  SW,
  inout  wire  DP,
  inout  wire  DN,
  inout  wire  SCL,
  inout  wire  SDA,
  inout  wire  CC1,
  inout  wire  CC2,
  inout  wire  TST,
  inout  wire  GPIO_TS,
  inout  wire  GPIO1,
  inout  wire  GPIO2,
  inout  wire  GPIO3,
  inout  wire  GPIO4,
  inout  wire  GPIO5,
  output logic LG,
  output logic HG,
  output logic GATE
);

  localparam int DEB_W = width_min1(DEB_LEN);
  localparam logic [DEB_W-1:0] DEB_TOP = DEB_W'(DEB_LEN - 1);

  logic [NUM_SYNC-1:0] pad_in, sync1_q, sync2_q;
  logic cc1_s, cc2_s, tst_s, gpio_ts_s;

  logic             raw, raw_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             attached_q, attached_d;
  logic             orient_q, orient_d;
  logic             gate_q;
  logic             pwm_en;

  status_t             status;
  logic [NUM_GPIO-1:0] status_v;
  logic [NUM_GPIO-1:0] gpio_q, gpio_d;
  logic [NUM_GPIO-1:0] tcnt_q, tcnt_d;

  chip1127_if pif ();

  assign pad_in[SY_CSP]     = CSP;
  assign pad_in[SY_CSN]     = CSN;
  assign pad_in[SY_VFB]     = VFB;
  assign pad_in[SY_COMP]    = COMP;
  assign pad_in[SY_BST]     = BST;
  assign pad_in[SY_VDRV]    = VDRV;
  assign pad_in[SY_CC1]     = CC1;
  assign pad_in[SY_CC2]     = CC2;
  assign pad_in[SY_TST]     = TST;
  assign pad_in[SY_GPIO_TS] = GPIO_TS;

  assign cc1_s     = sync2_q[SY_CC1];
  assign cc2_s     = sync2_q[SY_CC2];
  assign tst_s     = sync2_q[SY_TST];
  assign gpio_ts_s = sync2_q[SY_GPIO_TS];

  assign raw    = cc1_s ^ cc2_s;
  assign pwm_en = attached_q & gpio_ts_s & ~pif.fault & ~tst_s;

  assign pif.pwm_en = pwm_en;
  assign pif.comp_s = sync2_q[SY_COMP];
  assign pif.csp_s  = sync2_q[SY_CSP];
  assign pif.csn_s  = sync2_q[SY_CSN];
  assign pif.bst_s  = sync2_q[SY_BST];
  assign pif.vdrv_s = sync2_q[SY_VDRV];
  assign pif.vfb_s  = sync2_q[SY_VFB];

  pwm_core #(
    .PERIOD_W  (PERIOD_W),
    .DMAX      (DMAX),
    .DEAD      (DEAD),
    .OCP_LIMIT (OCP_LIMIT)
  ) u_pwm_core (
    .clk (CLK),
    .rst (RST),
    .pif (pif.slave)
  );

  assign status.wrap     = pif.wrap;
  assign status.pwm_en   = pwm_en;
  assign status.fault    = pif.fault;
  assign status.attached = attached_q;
  assign status.orient   = orient_q;
  assign status_v        = status;

  always_comb begin
    // deb_cnt_q is the number of cycles raw has held its current value, saturating
    deb_cnt_d = deb_cnt_q;
    if (raw != raw_q) begin
      deb_cnt_d = DEB_W'(1);
    end else if (deb_cnt_q != DEB_TOP) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    attached_d = attached_q;
    if ((raw == raw_q) && (deb_cnt_q == DEB_TOP)) attached_d = raw;

    orient_d = (attached_d && !attached_q) ? cc2_s : orient_q;

    tcnt_d = tst_s ? tcnt_q + 1'b1 : '0;
    gpio_d = tst_s ? tcnt_q : status_v;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      raw_q      <= 1'b0;
      deb_cnt_q  <= '0;
      attached_q <= 1'b0;
      orient_q   <= 1'b0;
      gate_q     <= 1'b0;
      gpio_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      sync1_q    <= pad_in;
      sync2_q    <= sync1_q;
      raw_q      <= raw;
      deb_cnt_q  <= deb_cnt_d;
      attached_q <= attached_d;
      orient_q   <= orient_d;
      gate_q     <= attached_q & ~tst_s;
      gpio_q     <= gpio_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign HG   = pif.hg;
  assign LG   = pif.lg;
  assign GATE = gate_q;

  assign GPIO1 = gpio_q[GPIO_ORIENT];
  assign GPIO2 = gpio_q[GPIO_ATTACHED];
  assign GPIO3 = gpio_q[GPIO_FAULT];
  assign GPIO4 = gpio_q[GPIO_PWM_EN];
  assign GPIO5 = gpio_q[GPIO_WRAP];

  // Reserved pads are never driven
  assign SW  = 1'bz;
  assign DP  = 1'bz;
  assign DN  = 1'bz;
  assign SCL = 1'bz;
  assign SDA = 1'bz;

endmodule

// File: tb/tb_chip_top_1127a0.sv
// Directed bench for chip_top_1127a0: attach debounce, duty ramp, OCP latch,
// mid-run reset and test mode, with hand-derived expected waveforms per PWM period.
module tb_chip_top_1127a0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic csp_r = 1'b0, csn_r = 1'b0, vfb_r = 1'b0, comp_r = 1'b0, bst_r = 1'b0;
  logic vdrv_r = 1'b0, cc1_r = 1'b0, cc2_r = 1'b0, tst_r = 1'b0, gpio_ts_r = 1'b0;

  wire csp_w, csn_w, vfb_w, comp_w, bst_w, vdrv_w, cc1_w, cc2_w, tst_w, gpio_ts_w;
  wire sw_w, dp_w, dn_w, scl_w, sda_w;
  wire g1, g2, g3, g4, g5;
  logic hg, lg, gate;

  assign csp_w     = csp_r;
  assign csn_w     = csn_r;
  assign vfb_w     = vfb_r;
  assign comp_w    = comp_r;
  assign bst_w     = bst_r;
  assign vdrv_w    = vdrv_r;
  assign cc1_w     = cc1_r;
  assign cc2_w     = cc2_r;
  assign tst_w     = tst_r;
  assign gpio_ts_w = gpio_ts_r;

  wire [4:0] gpio_v = {g5, g4, g3, g2, g1};

  chip_top_1127a0 dut (
    .CLK(clk), .RST(rst),
    .CSP(csp_w), .CSN(csn_w), .VFB(vfb_w), .COMP(comp_w), .BST(bst_w), .VDRV(vdrv_w),
    .SW(sw_w), .DP(dp_w), .DN(dn_w), .SCL(scl_w), .SDA(sda_w),
    .CC1(cc1_w), .CC2(cc2_w), .TST(tst_w), .GPIO_TS(gpio_ts_w),
    .GPIO1(g1), .GPIO2(g2), .GPIO3(g3), .GPIO4(g4), .GPIO5(g5),
    .LG(lg), .HG(hg), .GATE(gate)
  );

  int   checks = 0;
  int   failures = 0;
  int   exp_duty;
  logic overlap = 1'b0;
  logic acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int d, input logic c);
    if (c) return (d < 56) ? d + 1 : 56;
    return (d > 0) ? d - 1 : 0;
  endfunction

  function automatic logic [63:0] hg_mask(input int d);
    logic [63:0] m;
    for (int p = 0; p < 64; p++) m[p] = (p < d);
    return m;
  endfunction

  function automatic logic [63:0] lg_mask(input int d);
    logic [63:0] m;
    for (int p = 0; p < 64; p++) m[p] = (p >= d + 2) && (p <= 61);
    return m;
  endfunction

  // Waits for the wrap pulse on GPIO5, then records HG/LG for period phases 0..63.
  task automatic capture(input string tag, input logic [63:0] exp_hg, input logic [63:0] exp_lg);
    int n;
    logic [63:0] hm, lm;
    n = 0;
    hm = '0;
    lm = '0;
    while (g5 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_wrap_seen"}, {63'd0, g5}, 64'd1);
    for (int p = 0; p < 64; p++) begin
      tick();
      hm[p] = hg;
      lm[p] = lg;
      if (hg && lg) overlap = 1'b1;
    end
    $display("%s hg=%016h lg=%016h exp_hg=%016h exp_lg=%016h", tag, hm, lm, exp_hg, exp_lg);
    chk({tag, "_hg"}, hm, exp_hg);
    chk({tag, "_lg"}, lm, exp_lg);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_hg", {63'd0, hg}, 64'd0);
    chk("reset_lg", {63'd0, lg}, 64'd0);
    chk("reset_gate", {63'd0, gate}, 64'd0);
    chk("reset_gpio", {59'd0, gpio_v}, 64'd0);
    rst = 1'b0;

    // Attach: GATE rises exactly 19 cycles after the CC change
    cc1_r = 1'b1;
    repeat (18) tick();
    chk("attach_gate_early", {63'd0, gate}, 64'd0);
    tick();
    chk("attach_gate", {63'd0, gate}, 64'd1);
    chk("attach_gpio2", {63'd0, g2}, 64'd1);
    chk("attach_gpio1", {63'd0, g1}, 64'd0);
    $display("attach gate=%b gpio=%05b", gate, gpio_v);

    cc2_r = 1'b1;
    acc = 1'b1;
    repeat (10) begin tick(); acc &= gate; end
    cc2_r = 1'b0;
    repeat (30) begin tick(); acc &= gate; end
    chk("glitch_gate_held", {63'd0, acc}, 64'd1);

    // Duty ramp up to saturation
    bst_r = 1'b1; vdrv_r = 1'b1; comp_r = 1'b1; gpio_ts_r = 1'b1;
    exp_duty = step(0, comp_r);
    for (int k = 0; k < 60; k++) begin
      capture($sformatf("up%0d_d%0d", k, exp_duty), hg_mask(exp_duty), lg_mask(exp_duty));
      exp_duty = step(exp_duty, comp_r);
    end
    chk("run_gpio4", {63'd0, g4}, 64'd1);

    comp_r = 1'b0;
    for (int k = 0; k < 60; k++) begin
      capture($sformatf("dn%0d_d%0d", k, exp_duty), hg_mask(exp_duty), lg_mask(exp_duty));
      exp_duty = step(exp_duty, comp_r);
    end

    comp_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      capture($sformatf("re%0d_d%0d", k, exp_duty), hg_mask(exp_duty), lg_mask(exp_duty));
      exp_duty = step(exp_duty, comp_r);
    end

    // Over-current for four periods: HG survives only phases 0..1 of the first
    csp_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      capture($sformatf("ocp%0d_d%0d", k, exp_duty),
              (k == 0) ? hg_mask((exp_duty < 2) ? exp_duty : 2) : 64'd0,
              lg_mask(exp_duty));
      exp_duty = step(exp_duty, comp_r);
      if (k == 2) chk("ocp_fault_early", {63'd0, g3}, 64'd0);
    end
    tick();
    chk("ocp_fault", {63'd0, g3}, 64'd1);
    chk("ocp_pwm_off", {63'd0, g4}, 64'd0);
    csp_r = 1'b0;
    acc = 1'b0;
    repeat (150) begin tick(); acc |= hg | lg; end
    chk("fault_outputs_off", {63'd0, acc}, 64'd0);
    chk("fault_held", {63'd0, g3}, 64'd1);
    chk("hg_lg_overlap", {63'd0, overlap}, 64'd0);

    // Mid-operation reset
    rst = 1'b1;
    tick();
    chk("rst_hg", {63'd0, hg}, 64'd0);
    chk("rst_lg", {63'd0, lg}, 64'd0);
    chk("rst_gate", {63'd0, gate}, 64'd0);
    chk("rst_gpio", {59'd0, gpio_v}, 64'd0);
    rst = 1'b0;

    exp_duty = step(0, comp_r);
    for (int k = 0; k < 2; k++) begin
      capture($sformatf("post%0d_d%0d", k, exp_duty), hg_mask(exp_duty), lg_mask(exp_duty));
      exp_duty = step(exp_duty, comp_r);
    end

    // Test mode mid-period
    repeat (20) tick();
    tst_r = 1'b1;
    repeat (3) tick();
    chk("tst_hg", {63'd0, hg}, 64'd0);
    chk("tst_lg", {63'd0, lg}, 64'd0);
    chk("tst_gate", {63'd0, gate}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("tst_cnt%0d", i), {59'd0, gpio_v}, 64'(i % 32));
      tick();
    end
    $display("tst gpio=%05b", gpio_v);

    // Leaving test mode restarts the PWM from duty 0
    tst_r = 1'b0;
    repeat (4) tick();
    exp_duty = step(0, comp_r);
    capture($sformatf("tstexit_d%0d", exp_duty), hg_mask(exp_duty), lg_mask(exp_duty));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
